// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if
//   Bundles the FIFO handshake and register-bus signals of uart_reg_bridge.
//   master : the bridge side (pops RX FIFO, pushes TX FIFO, drives the bus).
//   slave  : the environment side (FIFOs and register file).
//   Signals:
//     rx_empty, r_data       receive FIFO status / show-ahead head byte
//     rd_uart                pop receive FIFO
//     tx_full                transmit FIFO full
//     wr_uart, w_data        push response byte into transmit FIFO
//     bus_addr, bus_wdata    register address / write data (held)
//     bus_we, bus_re         one-cycle write / read strobes
//     bus_rdata              read data, valid one cycle after bus_re
//     frame_err              one-cycle error pulse
interface uart_reg_bridge_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       frame_err;

  modport master (
    input  rx_empty, r_data, tx_full, bus_rdata,
    output rd_uart, wr_uart, w_data, bus_addr, bus_wdata, bus_we, bus_re, frame_err
  );

  modport slave (
    output rx_empty, r_data, tx_full, bus_rdata,
    input  rd_uart, wr_uart, w_data, bus_addr, bus_wdata, bus_we, bus_re, frame_err
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Register-access responder sitting on the user side of the UART FIFOs.
//   Parses 'W' addr data / 'R' addr frames from the receive FIFO, performs one
//   access on an 8-bit register bus and pushes one response byte ('K', the read
//   byte, or 'E') into the transmit FIFO. A stalled partial frame is dropped
//   after TIMEOUT idle cycles.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high reset
//     io     uart_reg_bridge_if.master (FIFO handshake + register bus)
//   Parameters:
//     TIMEOUT  cycles allowed between bytes of one frame
//     TO_BIT   timeout counter width (2**TO_BIT > TIMEOUT)
//   Build option:
//     UART_BRIDGE_CHKSUM_EN  when defined, each frame ends with an XOR
//                            checksum byte checked in the CHK state.
module uart_reg_bridge #(
  parameter int TIMEOUT = 50000,
  parameter int TO_BIT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_reg_bridge_if.master io
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] RDWAIT = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;
`ifdef UART_BRIDGE_CHKSUM_EN
  localparam logic [2:0] CHK    = 3'd6;
  // State entered once all address/data bytes of a frame are in.
  localparam logic [2:0] FIELDS_DONE = CHK;
`else
  localparam logic [2:0] FIELDS_DONE = EXEC;
`endif

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);
  localparam logic [TO_BIT-1:0] TO_ONE  = TO_BIT'(1);

  logic [2:0]        state;
  logic              is_wr;
  logic [TO_BIT-1:0] to_cnt;
  logic              in_frame;
  logic              accept;
  logic              timeout;

`ifdef UART_BRIDGE_CHKSUM_EN
  logic [7:0]        chk_acc;
  assign in_frame = (state == ADDR) || (state == DATA) || (state == CHK);
`else
  assign in_frame = (state == ADDR) || (state == DATA);
`endif

  // Reset gating keeps rd_uart at its reset value while reset is held.
  assign accept     = ~reset & ~io.rx_empty & ((state == IDLE) | in_frame);
  assign io.rd_uart = accept;
  // A byte present at the last count wins over the timeout.
  assign timeout    = in_frame & io.rx_empty & (to_cnt == TO_LAST);
  assign io.wr_uart = (state == RESP) & ~io.tx_full;
  assign io.bus_we  = (state == EXEC) & is_wr;
  assign io.bus_re  = (state == EXEC) & ~is_wr;

  // Inter-byte timeout counter: runs only while waiting for a frame byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= {TO_BIT{1'b0}};
    end else if (!in_frame || accept || timeout) begin
      to_cnt <= {TO_BIT{1'b0}};
    end else begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

`ifdef UART_BRIDGE_CHKSUM_EN
  // Running XOR of the frame bytes; restarts with the command byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_acc <= 8'h00;
    end else if (state == IDLE) begin
      chk_acc <= accept ? io.r_data : 8'h00;
    end else if (accept) begin
      chk_acc <= chk_acc ^ io.r_data;
    end else begin
      chk_acc <= chk_acc;
    end
  end
`endif

  // Frame parser, bus sequencer and response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      is_wr        <= 1'b0;
      io.bus_addr  <= 8'h00;
      io.bus_wdata <= 8'h00;
      io.w_data    <= 8'h00;
      io.frame_err <= 1'b0;
    end else begin
      io.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if ((io.r_data == CMD_W) || (io.r_data == CMD_R)) begin
              is_wr <= (io.r_data == CMD_W);
              state <= ADDR;
            end else begin
              io.w_data    <= RSP_E;
              io.frame_err <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            io.bus_addr <= io.r_data;
            state       <= is_wr ? DATA : FIELDS_DONE;
          end else if (timeout) begin
            io.frame_err <= 1'b1;
            state        <= IDLE;
          end
        end
        DATA: begin
          if (accept) begin
            io.bus_wdata <= io.r_data;
            state        <= FIELDS_DONE;
          end else if (timeout) begin
            io.frame_err <= 1'b1;
            state        <= IDLE;
          end
        end
`ifdef UART_BRIDGE_CHKSUM_EN
        CHK: begin
          if (accept) begin
            if (io.r_data == chk_acc) begin
              state <= EXEC;
            end else begin
              io.w_data    <= RSP_E;
              io.frame_err <= 1'b1;
              state        <= RESP;
            end
          end else if (timeout) begin
            io.frame_err <= 1'b1;
            state        <= IDLE;
          end
        end
`endif
        EXEC: begin
          if (is_wr) begin
            io.w_data <= RSP_K;
            state     <= RESP;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          io.w_data <= io.bus_rdata;
          state     <= RESP;
        end
        RESP: begin
          if (!io.tx_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
//   Directed bench for uart_reg_bridge with a queue-backed RX FIFO, a
//   recording TX FIFO and a register model that returns read data exactly one
//   cycle after bus_re. A short TIMEOUT keeps the stall tests brief.
module tb_uart_reg_bridge;
  localparam int TIMEOUT = 20;
  localparam int TO_BIT  = 5;

  logic clk;
  logic reset;
  uart_reg_bridge_if io ();

  uart_reg_bridge #(.TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cyc, push_cyc, we_cyc, re_cyc, ferr_cyc;
  int we_cnt, re_cnt, ferr_cnt;
  logic [7:0] we_addr, we_data, re_addr;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       tx_full_v = 1'b0;
  logic       re_prev = 1'b0;
  logic [7:0] re_prev_addr = 8'h00;
  logic [7:0] frame_x = 8'h00;
  logic [7:0] tx0, tx1;

  function automatic logic [7:0] bus_model(input logic [7:0] a);
    return (a == 8'h10) ? 8'h96 : (a ^ 8'hA5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs before the edge, advance.
  task automatic step();
    io.rx_empty  = (rx_q.size() == 0);
    io.r_data    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    io.tx_full   = tx_full_v;
    io.bus_rdata = re_prev ? bus_model(re_prev_addr) : 8'h00;
    #1;
    re_prev      = io.bus_re;
    re_prev_addr = io.bus_addr;
    if (io.rd_uart && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      pop_cyc = cyc;
    end
    if (io.wr_uart) begin
      tx_q.push_back(io.w_data);
      push_cyc = cyc;
    end
    if (io.bus_we) begin
      we_cnt++; we_cyc = cyc; we_addr = io.bus_addr; we_data = io.bus_wdata;
    end
    if (io.bus_re) begin
      re_cnt++; re_cyc = cyc; re_addr = io.bus_addr;
    end
    if (io.frame_err) begin
      ferr_cnt++; ferr_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    we_cnt = 0; re_cnt = 0; ferr_cnt = 0;
    pop_cyc = -100; push_cyc = -100; we_cyc = -100; re_cyc = -100; ferr_cyc = -100;
    tx_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    frame_x = frame_x ^ b;
  endtask

  // Closes a frame: appends the XOR checksum byte in checksum builds.
  task automatic send_end();
`ifdef UART_BRIDGE_CHKSUM_EN
    rx_q.push_back(frame_x);
`endif
    frame_x = 8'h00;
  endtask

  task automatic grab_tx();
    tx0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    tx1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
  endtask

  initial begin
    reset = 1'b1;
    clear_stats();
    // Reset state, with a byte waiting that must not be popped.
    rx_q.push_back(8'h57);
    run(3);
    check("rst_rd_uart",   {31'd0, io.rd_uart},   32'd0);
    check("rst_wr_uart",   {31'd0, io.wr_uart},   32'd0);
    check("rst_strobes",   {30'd0, io.bus_we, io.bus_re}, 32'd0);
    check("rst_frame_err", {31'd0, io.frame_err}, 32'd0);
    check("rst_regs",      {8'd0, io.w_data, io.bus_addr, io.bus_wdata}, 32'd0);
    rx_q.delete();
    reset = 1'b0;
    run(2);

    // Write 0x57 0x3A 0xC5.
    clear_stats();
    send(8'h57); send(8'h3A); send(8'hC5); send_end();
    run(10);
    grab_tx();
    check("wr_we_cnt",   we_cnt, 32'd1);
    check("wr_addr",     {24'd0, we_addr}, 32'h3A);
    check("wr_data",     {24'd0, we_data}, 32'hC5);
    check("wr_re_cnt",   re_cnt, 32'd0);
    check("wr_tx_cnt",   tx_q.size(), 32'd1);
    check("wr_resp",     {24'd0, tx0}, 32'h4B);
    check("wr_ferr",     ferr_cnt, 32'd0);
    check("wr_we_lat",   we_cyc - pop_cyc, 32'd1);
    check("wr_push_lat", push_cyc - pop_cyc, 32'd2);

    // Read address 0x10, model returns 0x96.
    clear_stats();
    send(8'h52); send(8'h10); send_end();
    run(10);
    grab_tx();
    check("rd_re_cnt",   re_cnt, 32'd1);
    check("rd_addr",     {24'd0, re_addr}, 32'h10);
    check("rd_we_cnt",   we_cnt, 32'd0);
    check("rd_tx_cnt",   tx_q.size(), 32'd1);
    check("rd_resp",     {24'd0, tx0}, 32'h96);
    check("rd_re_lat",   re_cyc - pop_cyc, 32'd1);
    check("rd_push_lat", push_cyc - pop_cyc, 32'd3);

    // Bad command 0x41, then read of 0x05 (model: 0x05^0xA5 = 0xA0).
    clear_stats();
    send(8'h41); frame_x = 8'h00;
    send(8'h52); send(8'h05); send_end();
    run(14);
    grab_tx();
    check("bad_tx_cnt", tx_q.size(), 32'd2);
    check("bad_resp_e", {24'd0, tx0}, 32'h45);
    check("bad_resp_rd", {24'd0, tx1}, 32'hA0);
    check("bad_ferr",   ferr_cnt, 32'd1);
    check("bad_re_addr", {24'd0, re_addr}, 32'h05);
    check("bad_we_cnt", we_cnt, 32'd0);

    // Timeout after 0x57 0x01, then a full write.
    clear_stats();
    send(8'h57); send(8'h01); frame_x = 8'h00;
    run(TIMEOUT + 10);
    check("to_ferr",     ferr_cnt, 32'd1);
    check("to_ferr_lat", ferr_cyc - pop_cyc, TIMEOUT + 1);
    check("to_strobes",  we_cnt + re_cnt, 32'd0);
    check("to_tx_cnt",   tx_q.size(), 32'd0);
    clear_stats();
    send(8'h57); send(8'h44); send(8'h99); send_end();
    run(10);
    grab_tx();
    check("to_wr_addr", {24'd0, we_addr}, 32'h44);
    check("to_wr_data", {24'd0, we_data}, 32'h99);
    check("to_wr_resp", {24'd0, tx0}, 32'h4B);

    // Byte arriving exactly at count TIMEOUT-1 is accepted.
    clear_stats();
    send(8'h57); send(8'h01);
    run(2);
    run(TIMEOUT - 1);
    send(8'h77); send_end();
    run(8);
    grab_tx();
    check("edge_ferr",  ferr_cnt, 32'd0);
    check("edge_we",    we_cnt, 32'd1);
    check("edge_data",  {24'd0, we_data}, 32'h77);
    check("edge_resp",  {24'd0, tx0}, 32'h4B);

    // Backpressure on a read, then reset in the middle of a write frame.
    clear_stats();
    tx_full_v = 1'b1;
    send(8'h52); send(8'h10); send_end();
    send(8'h57); send(8'h20); frame_x = 8'h00;
    run(10);
    check("bp_no_push",  tx_q.size(), 32'd0);
    check("bp_wr_uart",  {31'd0, io.wr_uart}, 32'd0);
    check("bp_w_data",   {24'd0, io.w_data}, 32'h96);
    check("bp_no_pop",   rx_q.size(), 32'd2);
    run(5);
    check("bp_w_hold",   {24'd0, io.w_data}, 32'h96);
    tx_full_v = 1'b0;
    step();
    grab_tx();
    check("bp_push_cnt", tx_q.size(), 32'd1);
    check("bp_push_val", {24'd0, tx0}, 32'h96);
    run(2);
    check("mid_popped",  rx_q.size(), 32'd0);
    check("mid_addr",    {24'd0, io.bus_addr}, 32'h20);
    clear_stats();
    reset = 1'b1;
    #1;
    check("mid_rst_regs", {8'd0, io.w_data, io.bus_addr, io.bus_wdata}, 32'd0);
    check("mid_rst_ctl",  {27'd0, io.rd_uart, io.wr_uart, io.bus_we, io.bus_re, io.frame_err}, 32'd0);
    run(2);
    reset = 1'b0;
    run(TIMEOUT + 5);
    check("mid_no_strobe", we_cnt + re_cnt, 32'd0);
    check("mid_no_tx",     tx_q.size(), 32'd0);
    check("mid_no_ferr",   ferr_cnt, 32'd0);

`ifdef UART_BRIDGE_CHKSUM_EN
    // Good checksum: 0x57^0x02^0x0F = 0x5A.
    clear_stats();
    rx_q.push_back(8'h57); rx_q.push_back(8'h02); rx_q.push_back(8'h0F); rx_q.push_back(8'h5A);
    run(10);
    grab_tx();
    check("ck_ok_we",   we_cnt, 32'd1);
    check("ck_ok_resp", {24'd0, tx0}, 32'h4B);
    // Bad checksum.
    clear_stats();
    rx_q.push_back(8'h57); rx_q.push_back(8'h02); rx_q.push_back(8'h0F); rx_q.push_back(8'h00);
    run(10);
    grab_tx();
    check("ck_bad_we",   we_cnt, 32'd0);
    check("ck_bad_resp", {24'd0, tx0}, 32'h45);
    check("ck_bad_ferr", ferr_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
